// File: rtl/seq_sched_pkg.sv
// Shared types for the bit-serial detector scheduler.
package seq_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/seq_detect_scheduler_if.sv
// Requester, detector and result signals of the detector scheduler.
interface seq_detect_scheduler_if #(
  parameter int WORD_W = 8,
  parameter int CNT_W  = $clog2(WORD_W + 1)
);
  logic              req0_valid;
  logic [WORD_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [WORD_W-1:0] req1_data;
  logic              req1_ready;
  logic              det_clr;
  logic              det_in;
  logic              det_step;
  logic              det_y;
  logic              res_valid;
  logic              res_id;
  logic [CNT_W-1:0]  res_count;
  logic              res_ready;

  // Scheduler side
  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, det_y, res_ready,
    output req0_ready, req1_ready, det_clr, det_in, det_step,
           res_valid, res_id, res_count
  );

  // Requesters / detector / result consumer side
  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, det_y, res_ready,
    input  req0_ready, req1_ready, det_clr, det_in, det_step,
           res_valid, res_id, res_count
  );
endinterface

// File: rtl/seq_bit_prescaler.sv
// Bit-period prescaler: o_tick marks the last clk cycle of each bit period.
module seq_bit_prescaler #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  assign o_tick = i_enable && (r_cnt == LAST);

  // Count 0..DIV-1 while enabled, wrapping after the tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/seq_detect_scheduler.sv
// Shares one bit-serial sequence detector between two word requesters:
// round-robin grant, MSB-first serialization, per-word match count.
module seq_detect_scheduler
  import seq_sched_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int DIV    = 4,
  parameter int CNT_W  = $clog2(WORD_W + 1)
) (
  input logic                   clk,
  input logic                   reset_n,
  seq_detect_scheduler_if.slave bus
);
  localparam int IW = $clog2(WORD_W);

  state_t            r_state;
  logic [WORD_W-1:0] r_shreg;
  logic [IW-1:0]     r_bit_idx;
  logic [CNT_W-1:0]  r_count;
  logic              r_id;
  logic              r_last_grant;

  logic w_idle;
  logic w_gnt0;
  logic w_gnt1;
  logic w_shift;
  logic w_clear;
  logic w_tick;

  // reset_n gates the grant so no ready is seen while reset is held
  assign w_idle  = (r_state == IDLE) && reset_n;
  assign w_gnt0  = bus.req0_valid && (!bus.req1_valid || (r_last_grant == REQ1));
  assign w_gnt1  = bus.req1_valid && (!bus.req0_valid || (r_last_grant == REQ0));
  assign w_shift = (r_state == SHIFT);
  assign w_clear = (r_state == CLEAR);

  assign bus.req0_ready = w_idle && w_gnt0;
  assign bus.req1_ready = w_idle && w_gnt1;
  assign bus.det_clr    = w_clear;
  assign bus.det_in     = w_shift && r_shreg[WORD_W-1];
  assign bus.det_step   = w_tick;
  assign bus.res_valid  = (r_state == DONE);
  assign bus.res_id     = r_id;
  assign bus.res_count  = r_count;

  seq_bit_prescaler #(.DIV(DIV)) u_prescaler (
    .clk      (clk),
    .rst_n    (reset_n),
    .i_clear  (w_clear),
    .i_enable (w_shift),
    .o_tick   (w_tick)
  );

  // Control FSM with shift register, bit index and match counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_shreg      <= '0;
      r_bit_idx    <= '0;
      r_count      <= '0;
      r_id         <= REQ0;
      r_last_grant <= REQ1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gnt0) begin
            r_shreg      <= bus.req0_data;
            r_id         <= REQ0;
            r_last_grant <= REQ0;
            r_state      <= CLEAR;
          end else if (w_gnt1) begin
            r_shreg      <= bus.req1_data;
            r_id         <= REQ1;
            r_last_grant <= REQ1;
            r_state      <= CLEAR;
          end
        end
        CLEAR: begin
          r_bit_idx <= IW'(WORD_W - 1);
          r_count   <= '0;
          r_state   <= SHIFT;
        end
        SHIFT: begin
          if (w_tick) begin
            r_count <= r_count + CNT_W'(bus.det_y);
            r_shreg <= {r_shreg[WORD_W-2:0], 1'b0};
            if (r_bit_idx == '0) begin
              r_state <= DONE;
            end else begin
              r_bit_idx <= r_bit_idx - 1'b1;
            end
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Self-checking bench for seq_detect_scheduler: ones-counting stub on a DIV=4
// instance, a behavioural 1100/1010/1001 detector on a DIV=1 instance.
module tb_seq_detect_scheduler;
  import seq_sched_pkg::*;

  localparam int W   = 8;
  localparam int DIV = 4;
  localparam int CW  = $clog2(W + 1);

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  seq_detect_scheduler_if #(.WORD_W(W), .CNT_W(CW)) bus ();
  seq_detect_scheduler_if #(.WORD_W(W), .CNT_W(CW)) bus1 ();

  seq_detect_scheduler #(.WORD_W(W), .DIV(DIV), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );
  seq_detect_scheduler #(.WORD_W(W), .DIV(1), .CNT_W(CW)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1)
  );

  // Stub detector: counts ones
  assign bus.det_y = bus.det_in;

  // Real detector for dut1: last three stepped bits plus the current bit
  logic [2:0] dh = 3'b000;
  int unsigned dn = 0;
  always @(posedge clk) begin
    if (bus1.det_clr) begin
      dh <= 3'b000;
      dn <= 0;
    end else if (bus1.det_step) begin
      dh <= {dh[1:0], bus1.det_in};
      if (dn < 3) dn <= dn + 1;
    end
  end
  assign bus1.det_y = (dn == 3) &&
    (({dh, bus1.det_in} == 4'b1100) || ({dh, bus1.det_in} == 4'b1010) ||
     ({dh, bus1.det_in} == 4'b1001));

  int checks = 0;
  int failures = 0;
  logic m_last = 1'b1;

  typedef struct {
    logic         v0;
    logic [W-1:0] d0;
    logic         v1;
    logic [W-1:0] d1;
    int           hold;
    logic         exp_id;
    int           exp_cnt;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic int popc(input logic [W-1:0] w);
    int n = 0;
    for (int i = 0; i < W; i++) n += int'(w[i]);
    return n;
  endfunction

  // Overlapping matches of 1100/1010/1001 in the MSB-first bit stream
  function automatic int ref_det(input logic [W-1:0] w);
    int n = 0;
    logic [W-1:0] s;
    for (int k = 3; k < W; k++) begin
      s = w >> (W - 1 - k);
      if ((s[3:0] == 4'b1100) || (s[3:0] == 4'b1010) || (s[3:0] == 4'b1001)) n++;
    end
    return n;
  endfunction

  function automatic logic pick(input logic v0, input logic v1, input logic last);
    if (v0 && v1) return ~last;
    return v0 ? 1'b0 : 1'b1;
  endfunction

  // One complete word on dut: grant, CLEAR, SHIFT timing, result hold, accept
  task automatic run_word(input logic v0, input logic [W-1:0] d0, input logic v1,
                          input logic [W-1:0] d1, input int hold,
                          input logic exp_id, input int exp_cnt);
    int lat = 2 + W * DIV;
    int idx;
    logic [W-1:0] wd;
    logic e_step, e_in;
    @(negedge clk);
    bus.req0_valid = v0; bus.req0_data = d0;
    bus.req1_valid = v1; bus.req1_data = d1;
    bus.res_ready  = 1'b0;
    #1;
    chk("grant_ready", {bus.req1_ready, bus.req0_ready}, exp_id ? 2'b10 : 2'b01);
    chk("idle_res_valid", bus.res_valid, 1'b0);
    wd = exp_id ? d1 : d0;
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk); #1;
      chk("busy_ready", {bus.req1_ready, bus.req0_ready}, 2'b00);
      chk("det_clr", bus.det_clr, c == 1);
      e_step = (c >= 2) && (c < lat) && (((c - 2) % DIV) == DIV - 1);
      chk("det_step", bus.det_step, e_step);
      e_in = 1'b0;
      if (c >= 2 && c < lat) begin
        idx  = W - 1 - (c - 2) / DIV;
        e_in = wd[idx];
      end
      chk("det_in", bus.det_in, e_in);
      chk("res_valid", bus.res_valid, c == lat);
    end
    chk("res_id", bus.res_id, exp_id);
    chk("res_count", bus.res_count, exp_cnt);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk); #1;
      chk("hold_valid", bus.res_valid, 1'b1);
      chk("hold_id", bus.res_id, exp_id);
      chk("hold_count", bus.res_count, exp_cnt);
      chk("hold_ready", {bus.req1_ready, bus.req0_ready}, 2'b00);
    end
    @(negedge clk);
    bus.res_ready = 1'b1;
    #1;
    chk("accept_valid", bus.res_valid, 1'b1);
    chk("accept_ready", {bus.req1_ready, bus.req0_ready}, 2'b00);
    m_last = exp_id;
  endtask

  // One word on dut1 (DIV=1, real detector)
  task automatic run_det(input logic [W-1:0] d);
    @(negedge clk);
    bus1.req0_valid = 1'b1; bus1.req0_data = d; bus1.res_ready = 1'b0;
    #1;
    chk("d1_ready", bus1.req0_ready, 1'b1);
    @(negedge clk);
    bus1.req0_valid = 1'b0;
    #1;
    chk("d1_clr", bus1.det_clr, 1'b1);
    for (int c = 2; c < 2 + W; c++) begin
      @(negedge clk); #1;
      chk("d1_step", bus1.det_step, 1'b1);
    end
    @(negedge clk); #1;
    chk("d1_res_valid", bus1.res_valid, 1'b1);
    chk("d1_count", bus1.res_count, ref_det(d));
    @(negedge clk);
    bus1.res_ready = 1'b1;
    @(negedge clk);
    bus1.res_ready = 1'b0;
  endtask

  initial begin
    logic v0, v1, eid;
    logic [W-1:0] d0, d1;

    tbl[0] = '{1'b1, 8'hA5, 1'b0, 8'h00, 0,  1'b0, 4};
    tbl[1] = '{1'b1, 8'h3C, 1'b1, 8'hC3, 0,  1'b1, 4};
    tbl[2] = '{1'b1, 8'h0F, 1'b1, 8'h01, 0,  1'b0, 4};
    tbl[3] = '{1'b1, 8'h11, 1'b1, 8'hF0, 10, 1'b1, 4};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 8'hFF, 0,  1'b1, 8};
    tbl[5] = '{1'b1, 8'h00, 1'b0, 8'h55, 2,  1'b0, 0};
    tbl[6] = '{1'b1, 8'h80, 1'b1, 8'h7F, 0,  1'b1, 7};
    tbl[7] = '{1'b1, 8'h01, 1'b1, 8'hFE, 1,  1'b0, 1};

    bus.req0_valid = 1'b1; bus.req0_data = 8'hA5;
    bus.req1_valid = 1'b0; bus.req1_data = '0; bus.res_ready = 1'b0;
    bus1.req0_valid = 1'b0; bus1.req0_data = '0;
    bus1.req1_valid = 1'b0; bus1.req1_data = '0; bus1.res_ready = 1'b0;

    // Reset values, with a requester already valid
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", {bus.req1_ready, bus.req0_ready}, 2'b00);
    chk("rst_clr", bus.det_clr, 1'b0);
    chk("rst_step", bus.det_step, 1'b0);
    chk("rst_in", bus.det_in, 1'b0);
    chk("rst_res", {bus.res_valid, bus.res_id, bus.res_count}, '0);
    @(posedge clk); #2;
    reset_n = 1'b1;
    m_last = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_word(tbl[i].v0, tbl[i].d0, tbl[i].v1, tbl[i].d1, tbl[i].hold,
               tbl[i].exp_id, tbl[i].exp_cnt);
    end

    // Reset in mid-SHIFT at cycle 15 of an A5 word from req0
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_data = 8'hA5;
    bus.req1_valid = 1'b0; bus.res_ready = 1'b0;
    #1;
    chk("mid_grant", bus.req0_ready, 1'b1);
    repeat (14) @(negedge clk);
    #1;
    chk("mid_partial_count", bus.res_count, 2);
    @(negedge clk);
    bus.req1_valid = 1'b1; bus.req1_data = 8'h3C;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_det", {bus.det_clr, bus.det_step, bus.det_in}, 3'b000);
    chk("mid_rst_res", {bus.res_valid, bus.res_id, bus.res_count}, '0);
    chk("mid_rst_ready", {bus.req1_ready, bus.req0_ready}, 2'b00);
    @(negedge clk); #1;
    chk("mid_rst_ready2", {bus.req1_ready, bus.req0_ready}, 2'b00);
    @(posedge clk); #2;
    reset_n = 1'b1;
    m_last = 1'b1;
    run_word(1'b1, 8'hA5, 1'b1, 8'h3C, 0, 1'b0, 4);
    run_word(1'b1, 8'hA5, 1'b1, 8'h3C, 0, pick(1'b1, 1'b1, m_last), 4);

    // Randomized words against the round-robin / popcount model
    for (int i = 0; i < 16; i++) begin
      v0 = 1'(($urandom % 2));
      v1 = v0 ? 1'(($urandom % 2)) : 1'b1;
      d0 = W'($urandom);
      d1 = W'($urandom);
      eid = pick(v0, v1, m_last);
      run_word(v0, d0, v1, d1, int'($urandom_range(0, 3)), eid, popc(eid ? d1 : d0));
    end
    @(negedge clk);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; bus.res_ready = 1'b0;

    // Real detector, back-to-back steps
    run_det(8'b1100_1010);
    for (int i = 0; i < 4; i++) run_det(W'($urandom));
    run_det(8'b1001_1001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
